// File: rtl/instr_fetch.sv
// Fetch-stage requester for instr_mem: issues sequential fetch addresses, captures
// the one-cycle-late instruction into a skid FIFO and hands {pc, instr} to decode.
module instr_fetch #(
   parameter int unsigned     WORD      = 32,
   parameter int unsigned     INSTR_LEN = 32,
   parameter logic [WORD-1:0] RESET_PC  = '0,
   parameter int unsigned     BUF_DEPTH = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [WORD-1:0]      imem_pc,
   input  logic [INSTR_LEN-1:0] imem_instr,
   input  logic                 br_taken,
   input  logic [WORD-1:0]      br_target,
   input  logic                 id_ready,
   output logic                 if_valid,
   output logic [INSTR_LEN-1:0] if_instr,
   output logic [WORD-1:0]      if_pc
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned OCC_W = CNT_W + 1;

   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [CNT_W-1:0]     count;
   logic                 inflight;
   logic [WORD-1:0]      inflight_pc;
   logic [WORD-1:0]      pc_buf    [BUF_DEPTH];
   logic [INSTR_LEN-1:0] instr_buf [BUF_DEPTH];

   logic                 deq_c;
   logic                 enq_c;
   logic                 issue_c;
   logic [OCC_W-1:0]     occ_c;
   logic [OCC_W-1:0]     limit_c;
   logic [WORD-1:0]      target_c;

   // Issue only if the word can land in the FIFO, counting the one already in flight.
   always_comb begin
      deq_c    = if_valid & id_ready;
      enq_c    = inflight & ~br_taken;
      occ_c    = OCC_W'(count) + OCC_W'(inflight);
      limit_c  = OCC_W'(BUF_DEPTH) + OCC_W'(deq_c);
      issue_c  = occ_c < limit_c;
      target_c = br_target & ~WORD'(3);
   end

   assign if_valid = (count != '0);
   assign if_instr = instr_buf[rd_ptr];
   assign if_pc    = pc_buf[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         imem_pc     <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            pc_buf[i]    <= '0;
            instr_buf[i] <= '0;
         end
      end else if (br_taken) begin
         // Redirect drops everything buffered or returning; a same-cycle handshake already belongs to decode.
         imem_pc  <= target_c;
         inflight <= 1'b0;
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
      end else begin
         if (issue_c) begin
            imem_pc     <= imem_pc + WORD'(4);
            inflight    <= 1'b1;
            inflight_pc <= imem_pc;
         end else begin
            inflight <= 1'b0;
         end
         if (enq_c) begin
            pc_buf[wr_ptr]    <= inflight_pc;
            instr_buf[wr_ptr] <= imem_instr;
            wr_ptr            <= wr_ptr + PTR_W'(1);
         end
         if (deq_c) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(enq_c) - CNT_W'(deq_c);
      end
   end

endmodule
